// File: rtl/chart_defs.sv
// Shared definitions for the chart sequencer: sequencer states, chart geometry,
// song identifiers and the hit-slot helper.
package chart_defs;

    localparam int CHART_LEN = 100;
    localparam int NUM_LANES = 3;

    localparam logic [4:0] SONG_TAKE_ON_ME                 = 5'd3;
    localparam logic [4:0] SONG_THROUGH_THE_FIRE_AND_FLAMES = 5'd15;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_COUNTDOWN,
        ST_PLAY,
        ST_DONE
    } seq_state_e;

    // Lane 0 = red, 1 = yellow, 2 = blue; bit CHART_LEN-1 is the hit slot.
    typedef logic [NUM_LANES-1:0][CHART_LEN-1:0] lanes_t;

    function automatic logic note_at_hit_slot(input lanes_t lanes);
        logic any;
        any = 1'b0;
        for (int l = 0; l < NUM_LANES; l++) begin
            any = any | lanes[l][CHART_LEN-1];
        end
        return any;
    endfunction

endpackage

// File: rtl/slot_timer.sv
// Beat divider: counts 0..TICKS_PER_SLOT-1 and flags the terminal count as a
// slot event; clear wins over hold, hold freezes the count and masks the event.
module slot_timer #(
    parameter int TICKS_PER_SLOT = 12_500_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic hold_i,
    output logic slot_event_o
);

    localparam int CW = (TICKS_PER_SLOT > 1) ? $clog2(TICKS_PER_SLOT) : 1;
    localparam logic [CW-1:0] TERM = CW'(TICKS_PER_SLOT - 1);

    logic [CW-1:0] count_q, count_d;

    always_comb begin
        // NOTE: every combinational output gets its default before any branch,
        // so no path leaves it unassigned and no latch is inferred.
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (!hold_i) begin
            count_d = (count_q == TERM) ? '0 : count_q + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign slot_event_o = !clear_i && !hold_i && (count_q == TERM);

endmodule

// File: rtl/chart_sequencer.sv
// Plays one song chart slot-by-slot: latches the song select, captures the
// loader's lane vectors, counts in, then shifts one slot per beat.
module chart_sequencer
    import chart_defs::*;
#(
    parameter int TICKS_PER_SLOT  = 12_500_000,
    parameter int WINDOW          = 10,
    parameter int COUNTDOWN_SLOTS = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 pause,
    input  logic [4:0]           song_req,
    output logic [4:0]           loader_song_select,
    input  logic [CHART_LEN-1:0] loader_red,
    input  logic [CHART_LEN-1:0] loader_yellow,
    input  logic [CHART_LEN-1:0] loader_blue,
    input  logic [7:0]           loader_total_notes,
    output logic [WINDOW-1:0]    win_red,
    output logic [WINDOW-1:0]    win_yellow,
    output logic [WINDOW-1:0]    win_blue,
    output logic                 slot_tick,
    output logic [6:0]           slot_index,
    output logic [7:0]           notes_left,
    output logic                 busy,
    output logic                 song_done
);

    // The count-in spans COUNTDOWN_SLOTS periods including the first PLAY
    // period, so COUNTDOWN itself consumes one slot event fewer.
    localparam int CD_LAST = (COUNTDOWN_SLOTS > 1) ? COUNTDOWN_SLOTS - 2 : 0;
    localparam int CDW     = (COUNTDOWN_SLOTS > 2) ? $clog2(COUNTDOWN_SLOTS - 1) : 1;

    seq_state_e   state_q, state_d;
    logic [4:0]   select_q, select_d;
    lanes_t       lanes_q, lanes_d;
    logic [6:0]   index_q, index_d;
    logic [7:0]   notes_q, notes_d;
    logic [CDW-1:0] cd_q, cd_d;
    logic         busy_q;
    logic         timer_clear;
    logic         slot_event;

    assign timer_clear = (state_q != ST_COUNTDOWN) && (state_q != ST_PLAY);

    slot_timer #(
        .TICKS_PER_SLOT(TICKS_PER_SLOT)
    ) u_slot_timer (
        .clk          (clk),
        .reset        (reset),
        .clear_i      (timer_clear),
        .hold_i       (pause),
        .slot_event_o (slot_event)
    );

    always_comb begin
        state_d  = state_q;
        select_d = select_q;
        lanes_d  = lanes_q;
        index_d  = index_q;
        notes_d  = notes_q;
        cd_d     = cd_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    select_d = song_req;
                    state_d  = ST_LOAD;
                end
            end
            ST_LOAD: begin
                lanes_d = {loader_blue, loader_yellow, loader_red};
                notes_d = loader_total_notes;
                cd_d    = '0;
                if (loader_total_notes == 8'd0) begin
                    state_d = ST_DONE;
                end else if (COUNTDOWN_SLOTS < 2) begin
                    state_d = ST_PLAY;
                end else begin
                    state_d = ST_COUNTDOWN;
                end
            end
            ST_COUNTDOWN: begin
                if (slot_event) begin
                    if (cd_q == CDW'(CD_LAST)) begin
                        state_d = ST_PLAY;
                    end else begin
                        cd_d = cd_q + 1'b1;
                    end
                end
            end
            ST_PLAY: begin
                if (slot_event) begin
                    for (int l = 0; l < NUM_LANES; l++) begin
                        lanes_d[l] = {lanes_q[l][CHART_LEN-2:0], 1'b0};
                    end
                    index_d = index_q + 7'd1;
                    if (note_at_hit_slot(lanes_q) && notes_q != 8'd0) begin
                        notes_d = notes_q - 8'd1;
                    end
                    if (index_q == 7'(CHART_LEN - 1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                lanes_d = '0;
                index_d = '0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            select_q <= '0;
            lanes_q  <= '0;
            index_q  <= '0;
            notes_q  <= '0;
            cd_q     <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            select_q <= select_d;
            lanes_q  <= lanes_d;
            index_q  <= index_d;
            notes_q  <= notes_d;
            cd_q     <= cd_d;
            busy_q   <= (state_d == ST_LOAD) || (state_d == ST_COUNTDOWN) ||
                        (state_d == ST_PLAY);
        end
    end

    assign loader_song_select = select_q;
    assign win_red            = lanes_q[0][CHART_LEN-1 -: WINDOW];
    assign win_yellow         = lanes_q[1][CHART_LEN-1 -: WINDOW];
    assign win_blue           = lanes_q[2][CHART_LEN-1 -: WINDOW];
    assign slot_index         = index_q;
    assign notes_left         = notes_q;
    assign busy               = busy_q;
    assign slot_tick          = (state_q == ST_PLAY) && slot_event;
    assign song_done          = (state_q == ST_DONE);

endmodule
